// File: rtl/tdc_pkg.sv
// tdc_pkg
// Shared definitions for the TDC hit path and the downstream readout FIFO:
//   COARSE_W_DEFAULT / NMUX_DEFAULT : default timestamp and tap-count widths
//   fine_w()                        : width needed to hold a tap count 0..NMUX
//   tdc_state_t                     : hit-detector FSM states
//   tdc_rec_t                       : record layout {bubble, coarse, fine}
package tdc_pkg;

  localparam int COARSE_W_DEFAULT = 16;
  localparam int NMUX_DEFAULT     = 4;

  function automatic int fine_w(input int nmux);
    return $clog2(nmux + 1);
  endfunction

  localparam int FINE_W_DEFAULT = $clog2(NMUX_DEFAULT + 1);

  typedef enum logic {
    ARMED = 1'b0,
    BUSY  = 1'b1
  } tdc_state_t;

  // Default-width record as seen by the readout FIFO. The encoder keeps the
  // same field order for non-default widths.
  typedef struct packed {
    logic                        bubble;
    logic [COARSE_W_DEFAULT-1:0] coarse;
    logic [FINE_W_DEFAULT-1:0]   fine;
  } tdc_rec_t;

endpackage

// File: rtl/therm_decode.sv
// therm_decode
// Purely combinational decode of a sampled thermometer code.
//   code   : sampled taps, bit 0 is the tap that fires first
//   count  : number of taps set (popcount)
//   bubble : 1 when the ones are not contiguous from bit 0
module therm_decode
  import tdc_pkg::*;
#(
  parameter int NMUX   = NMUX_DEFAULT,
  parameter int FINE_W = fine_w(NMUX)
) (
  input  logic [NMUX-1:0]   code,
  output logic [FINE_W-1:0] count,
  output logic              bubble
);

  always_comb begin
    count  = '0;
    bubble = 1'b0;
    for (int i = 0; i < NMUX; i++) begin
      count = count + FINE_W'(code[i]);
    end
    // A clean code never has a set tap above a clear one.
    for (int i = 1; i < NMUX; i++) begin
      if (code[i] && !code[i-1]) begin
        bubble = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder
// Samples the asynchronous delay-line taps, detects each hit and emits a
// {bubble, coarse, fine} timestamp record through a one-entry valid/ready
// output register.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   Z            : delay-line taps (asynchronous thermometer code)
//   en           : run enable; low holds the coarse counter at 0 and disarms
//   clr_ovf      : synchronous clear of the sticky overflow flag
//   ts_ready     : consumer accepts the current record
//   ts_valid     : record valid
//   ts_coarse    : coarse time of the hit
//   ts_fine      : number of taps set in the first sample
//   ts_bubble    : first sample was not a clean thermometer code
//   overflow     : sticky, a record was dropped under backpressure
module tdc_hit_encoder
  import tdc_pkg::*;
#(
  parameter int NMUX     = NMUX_DEFAULT,
  parameter int COARSE_W = COARSE_W_DEFAULT,
  parameter int FINE_W   = fine_w(NMUX)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NMUX-1:0]     Z,
  input  logic                en,
  input  logic                clr_ovf,
  input  logic                ts_ready,
  output logic                ts_valid,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_bubble,
  output logic                overflow
);

  typedef struct packed {
    logic                bubble;
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } rec_t;

  logic [NMUX-1:0]     s1;
  logic [NMUX-1:0]     s2;
  logic [COARSE_W-1:0] cnt;
  tdc_state_t          state;
  rec_t                out_rec;
  rec_t                new_rec;

  logic [FINE_W-1:0]   fine_code;
  logic                bubble_code;
  logic                hit_evt;
  logic                drain;
  logic                drop;

  // Plain two-flop synchroniser per tap; nothing may sit between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= Z;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + COARSE_W'(1);
    end
  end

  therm_decode #(
    .NMUX   (NMUX),
    .FINE_W (FINE_W)
  ) u_decode (
    .code   (s2),
    .count  (fine_code),
    .bubble (bubble_code)
  );

  assign hit_evt = (state == ARMED) && en && (|s2);
  assign drain   = ts_valid && ts_ready;
  assign drop    = hit_evt && ts_valid && !ts_ready;

  // The code seen in s2 entered s1 two edges ago, so cnt has advanced by two
  // since the cycle in which the hit actually arrived.
  assign new_rec.bubble = bubble_code;
  assign new_rec.coarse = cnt - COARSE_W'(2);
  assign new_rec.fine   = fine_code;

  // BUSY waits for one all-zero sample before another hit can be taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARMED;
    end else begin
      case (state)
        ARMED: if (hit_evt) state <= BUSY;
        BUSY:  if (!en || !(|s2)) state <= ARMED;
        default: state <= ARMED;
      endcase
    end
  end

  // Fields are only rewritten on a load, so they stay put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_valid <= 1'b0;
      out_rec  <= '0;
    end else if (hit_evt && (!ts_valid || ts_ready)) begin
      ts_valid <= 1'b1;
      out_rec  <= new_rec;
    end else if (drain) begin
      ts_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign ts_coarse = out_rec.coarse;
  assign ts_fine   = out_rec.fine;
  assign ts_bubble = out_rec.bubble;

endmodule
